sigmoid_grad_bwd: RTL and testbench

//  Backward-pass partner of the VAE sigmoid activation unit. Takes the forward

---
 rtl/sigmoid_grad_bwd.sv | 105 ++++++++++
 tb/tb_sigmoid_grad_bwd.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_grad_bwd.sv
// Sigmoid backward pass: gx = g * y * (1 - y) in signed Q6.10.
// Multi-cycle FSM with valid/ready on input and output; one transaction in flight.
module sigmoid_grad_bwd #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] g_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] gx_out,
  output logic                     busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC_W);

  typedef enum logic [2:0] {
    StIdle,
    StSq,
    StNrw,
    StMul,
    StOut,
    StHold
  } state_e;

  state_e                   state_q;
  logic signed [DATA_W-1:0] y_c;
  logic signed [DATA_W-1:0] y_c_q;
  logic signed [DATA_W-1:0] g_q;
  logic signed [DATA_W-1:0] s16_q;
  logic signed [PROD_W-1:0] sq_q;
  logic signed [PROD_W-1:0] p_q;

  // A sigmoid output lives in [0, 1]; anything outside is clamped before use.
  always_comb begin
    y_c = y_in;
    if (y_in[DATA_W-1]) begin
      y_c = '0;
    end else if (y_in > ONE) begin
      y_c = ONE;
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      y_c_q     <= '0;
      g_q       <= '0;
      sq_q      <= '0;
      s16_q     <= '0;
      p_q       <= '0;
      gx_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            y_c_q   <= y_c;
            g_q     <= g_in;
            state_q <= StSq;
          end
        end
        StSq: begin
          sq_q    <= PROD_W'(y_c_q) * PROD_W'(ONE - y_c_q);
          state_q <= StNrw;
        end
        StNrw: begin
          // y*(1-y) <= 0.25, so the narrowed factor is at most 256.
          s16_q   <= sq_q[FRAC_W+DATA_W-1:FRAC_W];
          state_q <= StMul;
        end
        StMul: begin
          p_q     <= PROD_W'(s16_q) * PROD_W'(g_q);
          state_q <= StOut;
        end
        StOut: begin
          // Bit slice of the product is an arithmetic shift: floor toward -inf.
          gx_out    <= p_q[FRAC_W+DATA_W-1:FRAC_W];
          out_valid <= 1'b1;
          state_q   <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sq_q[PROD_W-1:FRAC_W+DATA_W], sq_q[FRAC_W-1:0],
                         p_q[PROD_W-1:FRAC_W+DATA_W], p_q[FRAC_W-1:0]};

endmodule

// File: tb/tb_sigmoid_grad_bwd.sv
// Directed bench for sigmoid_grad_bwd: values, clamping, latency, stalls, throughput and reset.
module tb_sigmoid_grad_bwd;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] y_in;
  logic signed [15:0] g_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] gx_out;
  logic               busy;

  int errors;
  int checks;

  sigmoid_grad_bwd #(
    .DATA_W(16),
    .FRAC_W(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y_in     (y_in),
    .g_in     (g_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gx_out   (gx_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one pair, return right after the accept edge with garbage on the inputs.
  task automatic accept_pair(input logic signed [15:0] y, input logic signed [15:0] g);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    y_in     = y;
    g_in     = g;
    @(posedge clk); #1;
    in_valid = 1'b0;
    y_in     = 16'sh5a5a;
    g_in     = 16'sh7abc;
  endtask

  // Count edges until out_valid; 20 means the wait expired.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y_in      = '0;
    g_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (gx_out !== 16'sd0) begin errors++; $display("FAIL reset_gx got %0d want 0", gx_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc;
    accept_pair(16'sd512, 16'sd1024);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_valid(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_latency got %0d want 4", cyc); end
    checks++; if (gx_out !== 16'sd256) begin errors++; $display("FAIL basic_gx got %0d want 256", gx_out); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", out_valid); end
    checks++; if (gx_out !== 16'sd256) begin errors++; $display("FAIL basic_keep got %0d want 256", gx_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got %b want 1", in_ready); end
  endtask

  // y, g, expected gx worked out by hand.
  task automatic test_values();
    logic signed [15:0] ys [10] = '{16'sd256, 16'sd100, 16'sd100, 16'sd0, 16'sd1024,
                                    -16'sd100, 16'sd2000, 16'sd512, 16'sd512, 16'sd256};
    logic signed [15:0] gs [10] = '{-16'sd1024, 16'sd3, -16'sd3, 16'sd1024, 16'sd1024,
                                    16'sd1024, 16'sd1024, 16'sd32767, -16'sd32768, -16'sd1024};
    logic signed [15:0] ex [10] = '{-16'sd192, 16'sd0, -16'sd1, 16'sd0, 16'sd0,
                                    16'sd0, 16'sd0, 16'sd8191, -16'sd8192, -16'sd192};
    int cyc;
    for (int i = 0; i < 10; i++) begin
      accept_pair(ys[i], gs[i]);
      wait_valid(cyc);
      checks++;
      if (cyc !== 4 || gx_out !== ex[i]) begin
        errors++;
        $display("FAIL value[%0d] y=%0d g=%0d got gx=%0d lat=%0d want gx=%0d lat=4",
                 i, ys[i], gs[i], gx_out, cyc, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int cyc;
    out_ready = 1'b0;
    accept_pair(16'sd512, 16'sd1024);
    wait_valid(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL stall_latency got %0d want 4", cyc); end
    // Offer the next pair during HOLD; it must wait until IDLE.
    in_valid = 1'b1;
    y_in     = 16'sd256;
    g_in     = -16'sd1024;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || gx_out !== 16'sd256 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valid=%b gx=%0d in_ready=%b busy=%b want 1 256 0 1",
                 i, out_valid, gx_out, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_next_accept got busy=%b want 1", busy); end
    out_ready = 1'b1;
    wait_valid(cyc);
    checks++;
    if (cyc !== 4 || gx_out !== -16'sd192) begin
      errors++;
      $display("FAIL stall_next got gx=%0d lat=%0d want gx=-192 lat=4", gx_out, cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int seen;
    first     = -1;
    second    = -1;
    seen      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    y_in      = 16'sd256;
    g_in      = -16'sd1024;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        checks++;
        if (gx_out !== -16'sd192) begin errors++; $display("FAIL b2b_gx got %0d want -192", gx_out); end
        if (seen == 0) first = c;
        else if (seen == 1) second = c;
        seen++;
      end
    end
    in_valid = 1'b0;
    checks++; if (first !== 5) begin errors++; $display("FAIL b2b_first got %0d want 5", first); end
    checks++; if (second - first !== 6) begin errors++; $display("FAIL b2b_period got %0d want 6", second - first); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    accept_pair(16'sd512, 16'sd1024);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || gx_out !== 16'sd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset got valid=%b gx=%0d busy=%b want 0 0 0", out_valid, gx_out, busy);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got busy=%b want 0", busy); end
    accept_pair(16'sd512, 16'sd1024);
    wait_valid(cyc);
    checks++;
    if (cyc !== 4 || gx_out !== 16'sd256) begin
      errors++;
      $display("FAIL midreset_next got gx=%0d lat=%0d want gx=256 lat=4", gx_out, cyc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_values();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
